// File: rtl/game_flow_controller.sv
// Game flow FSM: start screen, level reset pulse, play/pause, life loss with serve delay,
// level progression and win/lose screens. All outputs decode from registered state.
module game_flow_controller #(
  parameter  int NUM_LIVES    = 3,
  parameter  int NUM_LEVELS   = 4,
  parameter  int BRICK_W      = 5,
  parameter  int RESET_CYCLES = 4,
  parameter  int SERVE_DELAY  = 50000000,
  localparam int LW           = $clog2(NUM_LIVES + 1),
  localparam int VW           = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ball_lost,
  input  logic [BRICK_W-1:0] bricks_remaining,
  input  logic               bricks_valid,
  input  logic               spacebar_pressed,
  input  logic               enter_pressed,
  input  logic               pause_pressed,
  input  logic               startscreen_done,
  output logic [2:0]         state_code,
  output logic               show_start_screen,
  output logic               game_over,
  output logic               game_won,
  output logic               paused,
  output logic               game_reset,
  output logic               clear_trigger,
  output logic               serve_reset,
  output logic [LW-1:0]      lives,
  output logic [VW-1:0]      level
);

  localparam logic [2:0] S_START   = 3'd0;
  localparam logic [2:0] S_PLAYING = 3'd1;
  localparam logic [2:0] S_PAUSED  = 3'd2;
  localparam logic [2:0] S_LOST    = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;
  localparam logic [2:0] S_OVER    = 3'd5;
  localparam logic [2:0] S_WON     = 3'd6;
  localparam logic [2:0] S_RESET   = 3'd7;

  localparam int CW_R = $clog2(RESET_CYCLES);
  localparam int CW_S = $clog2(SERVE_DELAY);
  localparam int CW   = (CW_R > CW_S) ? ((CW_R > 1) ? CW_R : 1) : ((CW_S > 1) ? CW_S : 1);

  localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [LW-1:0] LIVES_INIT = LW'(NUM_LIVES);
  localparam logic [VW-1:0] LEVEL_LAST = VW'(NUM_LEVELS - 1);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [VW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only advances while staying in a timed state, so every entry starts from zero.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    cnt_d   = '0;
    case (state_q)
      S_START: begin
        if (startscreen_done && enter_pressed) begin
          state_d = S_RESET;
          lives_d = LIVES_INIT;
          level_d = '0;
        end
      end
      S_RESET: begin
        if (cnt_q == RESET_LAST) state_d = S_PLAYING;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_PLAYING: begin
        if (ball_lost) begin
          if (lives_q <= LW'(1)) begin
            lives_d = '0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 1'b1;
            state_d = S_LOST;
          end
        end else if (bricks_valid && (bricks_remaining == '0)) begin
          if (level_q >= LEVEL_LAST) begin
            state_d = S_WON;
          end else begin
            level_d = level_q + 1'b1;
            state_d = S_CLEAR;
          end
        end else if (pause_pressed) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_pressed) state_d = S_PLAYING;
      end
      S_LOST: begin
        if (cnt_q == SERVE_LAST) state_d = S_PLAYING;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_CLEAR: begin
        if (spacebar_pressed) state_d = S_RESET;
      end
      S_OVER, S_WON: begin
        if (spacebar_pressed) begin
          state_d = S_RESET;
          lives_d = LIVES_INIT;
          level_d = '0;
        end
      end
      default: begin
        state_d = S_START;
        lives_d = LIVES_INIT;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_START;
      lives_q <= LIVES_INIT;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_code        = state_q;
  assign show_start_screen = (state_q == S_START);
  assign game_over         = (state_q == S_OVER);
  assign game_won          = (state_q == S_WON);
  assign paused            = (state_q == S_PAUSED);
  assign game_reset        = (state_q == S_RESET);
  assign clear_trigger     = (state_q == S_RESET) && (cnt_q == '0);
  assign serve_reset       = (state_q == S_LOST) && (cnt_q == '0);
  assign lives             = lives_q;
  assign level             = level_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed vector table, async-reset abort sequence and
// random stimulus, all checked against a countdown-based reference model of the game rules.
module tb_game_flow_controller;

  localparam int NUM_LIVES    = 3;
  localparam int NUM_LEVELS   = 4;
  localparam int BRICK_W      = 5;
  localparam int RESET_CYCLES = 4;
  localparam int SERVE_DELAY  = 8;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               ball_lost = 1'b0;
  logic [BRICK_W-1:0] bricks_remaining = 5'd7;
  logic               bricks_valid = 1'b0;
  logic               spacebar_pressed = 1'b0;
  logic               enter_pressed = 1'b0;
  logic               pause_pressed = 1'b0;
  logic               startscreen_done = 1'b0;
  logic [2:0]         state_code;
  logic               show_start_screen, game_over, game_won, paused;
  logic               game_reset, clear_trigger, serve_reset;
  logic [1:0]         lives;
  logic [1:0]         level;

  game_flow_controller #(
    .NUM_LIVES(NUM_LIVES), .NUM_LEVELS(NUM_LEVELS), .BRICK_W(BRICK_W),
    .RESET_CYCLES(RESET_CYCLES), .SERVE_DELAY(SERVE_DELAY)
  ) dut (
    .clk(clk), .resetn(resetn), .ball_lost(ball_lost), .bricks_remaining(bricks_remaining),
    .bricks_valid(bricks_valid), .spacebar_pressed(spacebar_pressed),
    .enter_pressed(enter_pressed), .pause_pressed(pause_pressed),
    .startscreen_done(startscreen_done), .state_code(state_code),
    .show_start_screen(show_start_screen), .game_over(game_over), .game_won(game_won),
    .paused(paused), .game_reset(game_reset), .clear_trigger(clear_trigger),
    .serve_reset(serve_reset), .lives(lives), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ball; bit bz; bit bv; bit sp; bit en; bit pa; bit sd;
  } in_t;

  typedef struct {
    int rep; in_t in; int st; int lv; int lvl;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game rules with a countdown of cycles left in timed screens.
  int m_st, m_lives, m_level, m_left;
  bit m_first;

  task automatic model_reset();
    m_st = 0; m_lives = NUM_LIVES; m_level = 0; m_left = 0; m_first = 0;
  endtask

  task automatic go(input int code, input int dur);
    m_st = code; m_left = dur; m_first = 1;
  endtask

  task automatic model_step(input in_t v);
    case (m_st)
      0: if (v.sd && v.en) begin m_lives = NUM_LIVES; m_level = 0; go(7, RESET_CYCLES); end
      7, 3: begin
        if (m_left == 1) go(1, 0);
        else begin m_left--; m_first = 0; end
      end
      1: begin
        if (v.ball) begin
          if (m_lives <= 1) begin m_lives = 0; go(5, 0); end
          else begin m_lives--; go(3, SERVE_DELAY); end
        end else if (v.bv && v.bz) begin
          if (m_level == NUM_LEVELS - 1) go(6, 0);
          else begin m_level++; go(4, 0); end
        end else if (v.pa) go(2, 0);
      end
      2: if (v.pa) go(1, 0);
      4: if (v.sp) go(7, RESET_CYCLES);
      default: if (v.sp) begin m_lives = NUM_LIVES; m_level = 0; go(7, RESET_CYCLES); end
    endcase
  endtask

  task automatic check_model(input string name);
    logic [13:0] act, exp;
    act = {state_code, show_start_screen, game_over, game_won, paused,
           game_reset, clear_trigger, serve_reset, lives, level};
    exp = {3'(m_st), 1'(m_st == 0), 1'(m_st == 5), 1'(m_st == 6), 1'(m_st == 2),
           1'(m_st == 7), 1'(m_st == 7 && m_first), 1'(m_st == 3 && m_first),
           2'(m_lives), 2'(m_level)};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t outputs got=%h expected=%h (st,start,over,won,pause,grst,clr,serve,lives,level)",
               name, $time, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    ball_lost        = v.ball;
    bricks_remaining = v.bz ? 5'd0 : 5'd7;
    bricks_valid     = v.bv;
    spacebar_pressed = v.sp;
    enter_pressed    = v.en;
    pause_pressed    = v.pa;
    startscreen_done = v.sd;
  endtask

  task automatic tick(input in_t v, input string name);
    drive(v);
    @(posedge clk);
    if (!resetn) model_reset();
    else         model_step(v);
    #1;
    check_model(name);
  endtask

  task automatic add(input int rep, input bit ball, input bit bz, input bit bv, input bit sp,
                     input bit en, input bit pa, input bit sd, input int st, input int lv,
                     input int lvl);
    vec_t t;
    t.rep = rep; t.st = st; t.lv = lv; t.lvl = lvl;
    t.in.ball = ball; t.in.bz = bz; t.in.bv = bv; t.in.sp = sp;
    t.in.en = en; t.in.pa = pa; t.in.sd = sd;
    vecs.push_back(t);
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{default: 0};
    return v;
  endfunction

  initial begin
    in_t v;
    //  rep ball bz bv sp en pa sd   st lv lvl
    add(1, 0, 0, 0, 0, 0, 0, 1,  0, 3, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0,  0, 3, 0);
    add(1, 0, 0, 0, 0, 1, 0, 1,  7, 3, 0);
    add(3, 0, 0, 0, 0, 1, 1, 0,  7, 3, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,  1, 3, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0,  1, 3, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0,  4, 3, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0,  4, 3, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0,  7, 3, 1);
    add(3, 0, 0, 0, 0, 0, 0, 0,  7, 3, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,  1, 3, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0,  2, 3, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0,  2, 3, 1);
    add(1, 0, 1, 1, 0, 0, 0, 0,  2, 3, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0,  1, 3, 1);
    add(1, 1, 1, 1, 0, 0, 0, 0,  3, 2, 1);
    add(7, 0, 0, 0, 0, 0, 1, 0,  3, 2, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,  1, 2, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0,  3, 1, 1);
    add(7, 0, 0, 0, 0, 0, 0, 0,  3, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0,  5, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0,  5, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0,  7, 3, 0);
    add(3, 0, 0, 0, 0, 0, 0, 0,  7, 3, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,  1, 3, 0);
    for (int l = 1; l < NUM_LEVELS; l++) begin
      add(1, 0, 1, 1, 0, 0, 0, 0,  4, 3, l);
      add(1, 0, 0, 0, 1, 0, 0, 0,  7, 3, l);
      add(3, 0, 0, 0, 0, 0, 0, 0,  7, 3, l);
      add(1, 0, 0, 0, 0, 0, 0, 0,  1, 3, l);
    end
    add(1, 0, 1, 1, 0, 0, 0, 0,  6, 3, 3);
    add(1, 1, 0, 0, 0, 0, 1, 0,  6, 3, 3);
    add(1, 0, 0, 0, 1, 0, 0, 0,  7, 3, 0);

    // Reset state
    model_reset();
    #12;
    check_model("reset_state");
    resetn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        tick(vecs[i].in, $sformatf("vec%0d_model", i));
        n_checks++;
        if (state_code !== 3'(vecs[i].st) || lives !== 2'(vecs[i].lv) || level !== 2'(vecs[i].lvl)) begin
          n_fail++;
          $display("FAIL vec%0d rep%0d got st=%0d lives=%0d level=%0d expected st=%0d lives=%0d level=%0d",
                   i, r, state_code, lives, level, vecs[i].st, vecs[i].lv, vecs[i].lvl);
        end
      end
    end

    // Async reset in the middle of RESETTING must abort at once
    for (int k = 0; k < RESET_CYCLES + 2; k++) tick(idle(), "drain");
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_model("async_abort");
    n_checks++;
    if (game_reset !== 1'b0 || show_start_screen !== 1'b1 || lives !== 2'd3 || level !== 2'd0) begin
      n_fail++;
      $display("FAIL async_abort_flags got grst=%b start=%b lives=%0d level=%0d expected 0 1 3 0",
               game_reset, show_start_screen, lives, level);
    end
    tick(idle(), "held_reset");
    #3 resetn = 1'b1;
    v = idle(); v.sd = 1; v.en = 1;
    tick(v, "restart");
    tick(idle(), "resetting_c2");
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_model("abort_in_resetting");
    #3 resetn = 1'b1;

    // Randomised play against the model
    for (int k = 0; k < 4000; k++) begin
      v.ball = ($urandom_range(0, 11) == 0);
      v.bz   = ($urandom_range(0, 3) == 0);
      v.bv   = $urandom_range(0, 1);
      v.sp   = ($urandom_range(0, 3) == 0);
      v.en   = ($urandom_range(0, 3) == 0);
      v.pa   = ($urandom_range(0, 7) == 0);
      v.sd   = $urandom_range(0, 1);
      tick(v, "random");
      if ($urandom_range(0, 399) == 0) begin
        #2 resetn = 1'b0;
        #1 model_reset();
        check_model("random_async_reset");
        #2 resetn = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Parametrised successor to the single-life game state controller. Adds multiple lives, multi-level progression, pause, a win state and a stretchable reset pulse. Sits between PS/2 key decode, the ball/brick modules and the screen painters. All outputs are Moore-decoded from registered state, so there are no combinational input-to-output paths.

Parameters:
NUM_LIVES, 3, lives loaded at new game (>=1)
NUM_LEVELS, 4, levels per game (>=1)
BRICK_W, 5, width of bricks_remaining
RESET_CYCLES, 4, length of game_reset pulse (>=1)
SERVE_DELAY, 50000000, cycles held in LIFE_LOST before re-serve (>=1)
LW, $clog2(NUM_LIVES+1), lives width (localparam)
VW, max(1,$clog2(NUM_LEVELS)), level width (localparam)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
ball_lost  in  1  one-cycle pulse: ball passed paddle
bricks_remaining  in  BRICK_W  live brick count
bricks_valid  in  1  brick count reflects the loaded level
spacebar_pressed  in  1  one-cycle key pulse
enter_pressed  in  1  one-cycle key pulse
pause_pressed  in  1  one-cycle key pulse (P key)
startscreen_done  in  1  start screen fully painted
state_code  out  3  START=0 PLAYING=1 PAUSED=2 LIFE_LOST=3 LEVEL_CLEAR=4 GAME_OVER=5 GAME_WON=6 RESETTING=7
show_start_screen  out  1  high in START
game_over  out  1  high in GAME_OVER
game_won  out  1  high in GAME_WON
paused  out  1  high in PAUSED
game_reset  out  1  high for all RESETTING cycles
clear_trigger  out  1  high on first RESETTING cycle only
serve_reset  out  1  high on first LIFE_LOST cycle only
lives  out  LW  remaining lives
level  out  VW  current level, 0-based

Behaviour:
- Reset (async, resetn low): state=START, lives=NUM_LIVES, level=0, counter=0. Outputs: show_start_screen=1, state_code=0, all others 0.
- Every transition takes effect on the clk edge where the condition is sampled. Outputs follow one cycle later.
- START: startscreen_done && enter_pressed -> RESETTING. Load lives=NUM_LIVES, level=0.
- RESETTING: counter counts 0..RESET_CYCLES-1, then -> PLAYING. game_reset is high exactly RESET_CYCLES cycles. clear_trigger is high on the counter==0 cycle only. lives and level are held. All key inputs are ignored.
- PLAYING, priority order:
  1. ball_lost: if lives==1, lives=0 -> GAME_OVER. Else lives-=1 -> LIFE_LOST.
  2. bricks_valid && bricks_remaining==0: if level==NUM_LEVELS-1 -> GAME_WON. Else level+=1 -> LEVEL_CLEAR.
  3. pause_pressed -> PAUSED.
- ball_lost and an empty wall in the same cycle: ball_lost wins.
- bricks_remaining==0 with bricks_valid low never ends a level. This prevents a false win right after reset.
- PAUSED: pause_pressed -> PLAYING. ball_lost and brick inputs are ignored. lives and level are held.
- LIFE_LOST: counter counts SERVE_DELAY cycles, then -> PLAYING. No game_reset is issued, so bricks are kept. pause_pressed is ignored.
- LEVEL_CLEAR: spacebar_pressed -> RESETTING. The new level loads via game_reset.
- GAME_OVER / GAME_WON: spacebar_pressed -> RESETTING with lives=NUM_LIVES, level=0.
- Counter is shared, zeroed on every state entry, width max($clog2(RESET_CYCLES),$clog2(SERVE_DELAY),1). It never wraps.
- lives never underflows below 0. level never exceeds NUM_LEVELS-1.
- NUM_LEVELS=1: the first clear goes straight to GAME_WON. NUM_LIVES=1: the first ball_lost goes to GAME_OVER.
- Illegal state_code values are unreachable. A default branch returns the FSM to START.
- Reset asserted mid-RESETTING or mid-LIFE_LOST aborts immediately to reset values. Pulses drop asynchronously.

Test Plan:
- Reset, startscreen_done=1, enter pulse -> state_code 7 for exactly 4 cycles, game_reset 4 cycles, clear_trigger 1 cycle, then state_code 1, lives=3, level=0.
- In PLAYING, three ball_lost pulses each followed by SERVE_DELAY=8 (bench override) -> lives 2,1 with serve_reset 1-cycle pulses, then GAME_OVER with lives=0. Spacebar -> RESETTING, lives=3.
- bricks_remaining=0 with bricks_valid=0 -> stays PLAYING. With bricks_valid=1 -> LEVEL_CLEAR, level=1. Repeat to level 3 clear -> GAME_WON, game_won=1.
- Same-cycle ball_lost and bricks_remaining=0/bricks_valid=1 at lives=2 -> LIFE_LOST, lives=1, level unchanged.
- pause_pressed -> PAUSED, paused=1. ball_lost pulse ignored (lives unchanged). pause_pressed -> PLAYING.
- Assert resetn low during RESETTING cycle 2 -> immediate START, game_reset=0, show_start_screen=1, lives=3, level=0.
